// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : shared types and constants for the MEM-stage load/store unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_DMEM = 2'd1,
      REG_LEDR = 2'd2,
      REG_SW   = 2'd3
   } region_t;

   localparam int          DEF_DMEM_WORDS = 2048;
   localparam logic [31:0] DEF_LEDR_ADDR  = 32'h1000_0000;
   localparam logic [31:0] DEF_SW_ADDR    = 32'h1001_0000;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate the store operand so every enabled lane sees the right bits.
   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{data[7:0]}};
         2'b01:   w = {2{data[15:0]}};
         default: w = data;
      endcase
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sram.sv
// ---------------------------------------------------------------------------
// dmem_sram : byte-enabled single-port data RAM with registered read data
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_sram #(
   parameter int DEPTH = 2048
) (
   input  logic                     clk,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/lsu_dmem.sv
// ---------------------------------------------------------------------------
// lsu_dmem : MEM-stage load/store unit with data SRAM, LED and switch I/O
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int          DMEM_WORDS = DEF_DMEM_WORDS,
   parameter logic [31:0] LEDR_ADDR  = DEF_LEDR_ADDR,
   parameter logic [31:0] SW_ADDR    = DEF_SW_ADDR
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_stall,
   input  logic        i_valid,
   input  logic        i_mem_re,
   input  logic        i_mem_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_io_sw,
   output logic [31:0] o_ld_data,
   output logic        o_misaligned,
   output logic [31:0] o_io_ledr
);

   localparam int          AW         = $clog2(DMEM_WORDS);
   localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) * 33'd4;

   logic          accept;
   logic          misaligned;
   logic          commit;
   region_t       region;
   logic [AW-1:0] idx;
   logic [AW-1:0] held_idx;
   logic [AW-1:0] sram_addr;
   logic [3:0]    be;
   logic [3:0]    sram_we;
   logic [31:0]   wdata;
   logic [31:0]   rdata;

   logic [31:0]   sw_meta;
   logic [31:0]   sw_sync;
   logic [31:0]   ledr;
   region_t       ld_region;
   logic [1:0]    ld_off;
   logic [2:0]    ld_f3;
   logic [31:0]   io_word;
   logic          mis_q;

   logic [31:0]   src_word;
   logic [31:0]   lane;

   always_comb begin
      accept = i_valid & (i_mem_re | i_mem_we) & ~i_stall;

      case (i_funct3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = i_addr[0];
         default: misaligned = |i_addr[1:0];
      endcase

      if ({1'b0, i_addr} < DMEM_BYTES)
         region = REG_DMEM;
      else if (i_addr[31:2] == LEDR_ADDR[31:2])
         region = REG_LEDR;
      else if (i_addr[31:2] == SW_ADDR[31:2])
         region = REG_SW;
      else
         region = REG_NONE;

      idx    = i_addr[2 +: AW];
      be     = store_be(i_funct3, i_addr[1:0]);
      wdata  = store_lanes(i_funct3, i_st_data);
      // Gating on reset keeps a store caught in a reset cycle out of the RAM.
      commit = accept & i_mem_we & ~misaligned & i_reset_n;

      sram_we   = (commit && region == REG_DMEM) ? be : 4'b0000;
      // Re-presenting the last load index keeps rdata frozen across stalls.
      sram_addr = accept ? idx : held_idx;
   end

   dmem_sram #(
      .DEPTH (DMEM_WORDS)
   ) u_sram (
      .clk   (i_clk),
      .we    (sram_we),
      .addr  (sram_addr),
      .wdata (wdata),
      .rdata (rdata)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         ledr      <= '0;
         ld_region <= REG_NONE;
         ld_off    <= '0;
         ld_f3     <= '0;
         io_word   <= '0;
         mis_q     <= 1'b0;
         held_idx  <= '0;
      end else begin
         sw_meta <= i_io_sw;
         sw_sync <= sw_meta;
         mis_q   <= accept & misaligned;

         if (commit && region == REG_LEDR) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) begin
                  ledr[i*8 +: 8] <= wdata[i*8 +: 8];
               end
            end
         end

         if (!i_stall) begin
            ld_region <= (accept & i_mem_re & ~misaligned) ? region : REG_NONE;
            if (accept) begin
               ld_off   <= i_addr[1:0];
               ld_f3    <= i_funct3;
               held_idx <= idx;
               io_word  <= (region == REG_LEDR) ? ledr : sw_sync;
            end
         end
      end
   end

   always_comb begin
      src_word = (ld_region == REG_DMEM) ? rdata : io_word;
      lane     = src_word >> {ld_off, 3'b000};
      case (ld_f3)
         F3_B:    o_ld_data = {{24{lane[7]}}, lane[7:0]};
         F3_BU:   o_ld_data = {24'h0, lane[7:0]};
         F3_H:    o_ld_data = {{16{lane[15]}}, lane[15:0]};
         F3_HU:   o_ld_data = {16'h0, lane[15:0]};
         default: o_ld_data = src_word;
      endcase
      if (ld_region == REG_NONE) begin
         o_ld_data = '0;
      end
   end

   assign o_misaligned = mis_q;
   assign o_io_ledr    = ledr;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dmem.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem : scoreboard bench for lsu_dmem using a small memory/IO model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_dmem;
   import lsu_pkg::*;

   localparam int          WORDS = 2048;
   localparam logic [31:0] LEDR  = 32'h1000_0000;
   localparam logic [31:0] SWA   = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        reset_n, stall, valid, mem_re, mem_we;
   logic [2:0]  funct3;
   logic [31:0] addr, st_data, io_sw;
   logic [31:0] ld_data, io_ledr;
   logic        misaligned;

   lsu_dmem #(
      .DMEM_WORDS (WORDS),
      .LEDR_ADDR  (LEDR),
      .SW_ADDR    (SWA)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (reset_n),
      .i_stall      (stall),
      .i_valid      (valid),
      .i_mem_re     (mem_re),
      .i_mem_we     (mem_we),
      .i_funct3     (funct3),
      .i_addr       (addr),
      .i_st_data    (st_data),
      .i_io_sw      (io_sw),
      .o_ld_data    (ld_data),
      .o_misaligned (misaligned),
      .o_io_ledr    (io_ledr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] ld;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem_m [int];
   logic [31:0] ledr_m  = '0;
   logic [31:0] sw_m    = '0;
   logic [31:0] last_ld = '0;
   int          checks  = 0;
   int          errors  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
      logic [31:0] s;
      s = w >> (8 * off);
      case (f3)
         F3_B:    return {{24{s[7]}}, s[7:0]};
         F3_BU:   return {24'h0, s[7:0]};
         F3_H:    return {{16{s[15]}}, s[15:0]};
         F3_HU:   return {16'h0, s[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic op(input string tag, input logic rst_n, input logic stl, input logic v,
                     input logic re, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
      logic        acc, mis, in_dmem;
      logic [3:0]  be;
      logic [31:0] wd, w, exp_ld;
      int          idx;
      exp_t        e;

      acc     = rst_n & v & (re | we) & ~stl;
      mis     = (f3[1:0] == 2'b01) ? a[0] : (f3[1:0] == 2'b00) ? 1'b0 : (a[1:0] != 2'b00);
      in_dmem = (a < WORDS * 4);
      idx     = int'(a[31:2]);
      case (f3[1:0])
         2'b00:   begin be = 4'b0001 << a[1:0]; wd = {4{d[7:0]}};  end
         2'b01:   begin be = 4'b0011 << a[1:0]; wd = {2{d[15:0]}}; end
         default: begin be = 4'b1111;           wd = d;            end
      endcase

      exp_ld = '0;
      if (!rst_n) begin
         ledr_m = '0;
      end else if (stl) begin
         exp_ld = last_ld;
      end else if (acc && re && !mis) begin
         if (in_dmem)                 w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
         else if (a[31:2] == LEDR[31:2]) w = ledr_m;
         else if (a[31:2] == SWA[31:2])  w = sw_m;
         else                         w = 32'h0;
         exp_ld = fmt(w, a[1:0], f3);
      end

      if (acc && we && !mis) begin
         if (in_dmem) begin
            w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
            mem_m[idx] = w;
         end else if (a[31:2] == LEDR[31:2]) begin
            for (int i = 0; i < 4; i++) if (be[i]) ledr_m[i*8 +: 8] = wd[i*8 +: 8];
         end
      end

      e.tag = tag;
      e.ld  = exp_ld;
      e.mis = acc & mis;
      sb.push_back(e);

      reset_n = rst_n;
      stall   = stl;
      valid   = v;
      mem_re  = re;
      mem_we  = we;
      funct3  = f3;
      addr    = a;
      st_data = d;

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, "/ld"}, ld_data, e.ld);
      check({e.tag, "/mis"}, {31'h0, misaligned}, {31'h0, e.mis});
      check({e.tag, "/ledr"}, io_ledr, ledr_m);
      last_ld = e.ld;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; stall = 1'b0; valid = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
      funct3 = '0; addr = '0; st_data = '0; io_sw = '0;

      op("rst0", 0, 0, 0, 0, 0, F3_W, 32'h0, 32'h0);
      op("rst1", 0, 0, 0, 0, 0, F3_W, 32'h0, 32'h0);
      op("idle", 1, 0, 0, 0, 0, F3_W, 32'h0, 32'h0);

      op("sw100", 1, 0, 1, 0, 1, F3_W, 32'h100, 32'hDEADBEEF);
      op("lw100", 1, 0, 1, 1, 0, F3_W, 32'h100, 32'h0);

      op("sw200",  1, 0, 1, 0, 1, F3_W,  32'h200, 32'h0);
      op("sb203",  1, 0, 1, 0, 1, F3_B,  32'h203, 32'h12345680);
      op("lb203",  1, 0, 1, 1, 0, F3_B,  32'h203, 32'h0);
      op("lbu203", 1, 0, 1, 1, 0, F3_BU, 32'h203, 32'h0);
      op("lw200",  1, 0, 1, 1, 0, F3_W,  32'h200, 32'h0);
      op("lh202",  1, 0, 1, 1, 0, F3_H,  32'h202, 32'h0);
      op("lhu202", 1, 0, 1, 1, 0, F3_HU, 32'h202, 32'h0);

      op("sh101",  1, 0, 1, 0, 1, F3_H, 32'h101, 32'h0000BEEF);
      op("lw100b", 1, 0, 1, 1, 0, F3_W, 32'h100, 32'h0);
      op("lw102",  1, 0, 1, 1, 0, F3_W, 32'h102, 32'h0);
      op("idle2",  1, 0, 0, 0, 0, F3_W, 32'h0,   32'h0);

      op("swled", 1, 0, 1, 0, 1, F3_W, LEDR,          32'h000000FF);
      op("sbled", 1, 0, 1, 0, 1, F3_B, LEDR + 32'd1,  32'h000000AA);
      op("lwled", 1, 0, 1, 1, 0, F3_W, LEDR,          32'h0);
      op("shled", 1, 0, 1, 0, 1, F3_H, LEDR + 32'd2,  32'h00001234);
      op("lbled", 1, 0, 1, 1, 0, F3_B, LEDR + 32'd3,  32'h0);

      io_sw = 32'h5;
      sw_m  = 32'h5;
      op("swait0", 1, 0, 0, 0, 0, F3_W, 32'h0, 32'h0);
      op("swait1", 1, 0, 0, 0, 0, F3_W, 32'h0, 32'h0);
      op("lwsw",   1, 0, 1, 1, 0, F3_W, SWA,   32'h0);

      op("lwst",   1, 0, 1, 1, 0, F3_W, 32'h100, 32'h0);
      op("stall0", 1, 1, 1, 1, 0, F3_W, 32'h200, 32'h0);
      op("stall1", 1, 1, 1, 1, 0, F3_W, 32'h200, 32'h0);
      op("stall2", 1, 1, 1, 1, 0, F3_W, 32'h200, 32'h0);
      op("ststl",  1, 1, 1, 0, 1, F3_W, 32'h100, 32'h0);
      op("lwpost", 1, 0, 1, 1, 0, F3_W, 32'h100, 32'h0);

      op("sw300",  1, 0, 1, 0, 1, F3_W, 32'h300, 32'h11111111);
      op("strst",  0, 0, 1, 0, 1, F3_W, 32'h300, 32'h22222222);
      op("lw300",  1, 0, 1, 1, 0, F3_W, 32'h300, 32'h0);

      op("swtop",  1, 0, 1, 0, 1, F3_W, WORDS * 4 - 4, 32'hCAFEF00D);
      op("lwtop",  1, 0, 1, 1, 0, F3_W, WORDS * 4 - 4, 32'h0);
      op("sw0",    1, 0, 1, 0, 1, F3_W, 32'h0,         32'h0BADCAFE);
      op("swend",  1, 0, 1, 0, 1, F3_W, WORDS * 4,     32'hFFFFFFFF);
      op("lwend",  1, 0, 1, 1, 0, F3_W, WORDS * 4,     32'h0);
      op("lw0",    1, 0, 1, 1, 0, F3_W, 32'h0,         32'h0);
      op("idle3",  1, 0, 0, 0, 0, F3_W, 32'h0,         32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
